keypad_row_scanner: RTL and testbench

Drives the row lines of the 4x4 matrix keypad and samples its column lines, producing one debounced 4-bit key code per physical press. It is the matrix-side front end that feeds the digit-entry logic ahead of the adder and 7-segment display path. Row outputs and column inputs are active-low, with external pull-ups on the columns.

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/sync_2ff.sv | 30 +++
 rtl/keypad_row_scanner.sv | 175 +++++++++++++++++
 tb/tb_keypad_row_scanner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner: FSM states,
// special key codes and the row/column to key-code map.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // Keypad legend, row by row: "1 2 3 A", "4 5 6 B", "7 8 9 C", "* 0 # D".
   function automatic logic [3:0] keymap(input logic [1:0] row_idx,
                                         input logic [1:0] col_idx);
      logic [3:0] code;
      code = 4'h0;
      case ({row_idx, col_idx})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = KEY_STAR;
         4'hD: code = 4'h0;
         4'hE: code = KEY_HASH;
         4'hF: code = 4'hD;
      endcase
      return code;
   endfunction

   // Index of the lowest column pulled low; callers only use it when at
   // least one column is low.
   function automatic logic [1:0] lowest_low(input logic [3:0] col_n);
      logic [1:0] idx;
      idx = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!col_n[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous inputs such as keypad columns.
module sync_2ff #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Capture the asynchronous input and let the first stage settle for a cycle.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so r_sync takes the old r_meta; blocking
      // here would collapse the two stages into one flop.
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

// File: rtl/keypad_row_scanner.sv
// 4x4 keypad front end: rotates a one-cold row drive, samples the synchronized
// active-low columns once per row dwell, debounces press and release, and
// emits one key code per press.
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat while a key is held.
module keypad_row_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 10,
   parameter int REPEAT_CNT   = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_pressed
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_CNT);

   if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_params
      $error("keypad_row_scanner: SCAN_DIV >= 2, DEBOUNCE_CNT >= 1, REPEAT_CNT >= 1");
   end

   logic [3:0]    w_col_s;
   logic          w_sample;
   logic          w_any_low;
   logic [DW-1:0] r_div;
   state_t        r_state,    w_state_nxt;
   logic [1:0]    r_row_idx,  w_row_idx_nxt;
   logic [1:0]    r_col_idx,  w_col_idx_nxt;
   logic [CW-1:0] r_match,    w_match_nxt;
   logic [CW-1:0] r_release,  w_release_nxt;
   logic [3:0]    r_key_code, w_code_nxt;
   logic          r_key_valid, w_valid_nxt;
   logic          r_key_pressed, w_pressed_nxt;
`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CNT + 1);
   localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CNT);
   logic [RW-1:0] r_repeat, w_repeat_nxt;
`endif

   sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_col_sync (
      .clk (clk),
      .rst (rst),
      .d   (col),
      .q   (w_col_s)
   );

   assign w_sample  = (r_div == DIV_LAST);
   assign w_any_low = ~&w_col_s;

   // Row dwell timer; free-running so sample points stay evenly spaced in every state.
   always_ff @(posedge clk) begin
      if (rst)           r_div <= '0;
      else if (w_sample) r_div <= '0;
      else               r_div <= r_div + DW'(1);
   end

   // Next-state and output decisions, evaluated only at sample points.
   always_comb begin
      // NOTE: every target gets its hold value first so no path infers a latch.
      w_state_nxt   = r_state;
      w_row_idx_nxt = r_row_idx;
      w_col_idx_nxt = r_col_idx;
      w_match_nxt   = r_match;
      w_release_nxt = r_release;
      w_code_nxt    = r_key_code;
      w_valid_nxt   = 1'b0;
      w_pressed_nxt = r_key_pressed;
`ifdef KEYPAD_REPEAT_EN
      w_repeat_nxt  = r_repeat;
`endif
      if (w_sample) begin
         case (r_state)
            SCAN: begin
               if (w_any_low) begin
                  w_col_idx_nxt = lowest_low(w_col_s);
                  w_match_nxt   = '0;
                  w_state_nxt   = DEBOUNCE;
               end else begin
                  w_row_idx_nxt = r_row_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (!w_col_s[r_col_idx]) begin
                  if (r_match + CW'(1) == DB_MAX) begin
                     w_code_nxt    = keymap(r_row_idx, r_col_idx);
                     w_valid_nxt   = 1'b1;
                     w_pressed_nxt = 1'b1;
                     w_match_nxt   = '0;
                     w_release_nxt = '0;
                     w_state_nxt   = HELD;
`ifdef KEYPAD_REPEAT_EN
                     w_repeat_nxt  = '0;
`endif
                  end else begin
                     w_match_nxt = r_match + CW'(1);
                  end
               end else begin
                  // A bounce abandons this candidate and moves on.
                  w_row_idx_nxt = r_row_idx + 2'd1;
                  w_state_nxt   = SCAN;
               end
            end
            HELD: begin
               if (w_col_s[r_col_idx]) begin
`ifdef KEYPAD_REPEAT_EN
                  w_repeat_nxt = '0;
`endif
                  if (r_release + CW'(1) == DB_MAX) begin
                     w_release_nxt = '0;
                     w_pressed_nxt = 1'b0;
                     w_row_idx_nxt = r_row_idx + 2'd1;
                     w_state_nxt   = SCAN;
                  end else begin
                     w_release_nxt = r_release + CW'(1);
                  end
               end else begin
                  w_release_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
                  if (r_repeat + RW'(1) == REP_MAX) begin
                     w_valid_nxt  = 1'b1;
                     w_repeat_nxt = '0;
                  end else begin
                     w_repeat_nxt = r_repeat + RW'(1);
                  end
`endif
               end
            end
            default: w_state_nxt = SCAN;
         endcase
      end
   end

   // State register; reset discards any key being debounced or held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= SCAN;
         r_row_idx     <= 2'd0;
         r_col_idx     <= 2'd0;
         r_match       <= '0;
         r_release     <= '0;
         r_key_code    <= 4'h0;
         r_key_valid   <= 1'b0;
         r_key_pressed <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         r_repeat      <= '0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_row_idx     <= w_row_idx_nxt;
         r_col_idx     <= w_col_idx_nxt;
         r_match       <= w_match_nxt;
         r_release     <= w_release_nxt;
         r_key_code    <= w_code_nxt;
         r_key_valid   <= w_valid_nxt;
         r_key_pressed <= w_pressed_nxt;
`ifdef KEYPAD_REPEAT_EN
         r_repeat      <= w_repeat_nxt;
`endif
      end
   end

   assign row         = ~(4'b0001 << r_row_idx);
   assign key_code    = r_key_code;
   assign key_valid   = r_key_valid;
   assign key_pressed = r_key_pressed;

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Self-checking bench for keypad_row_scanner: a keypad model drives the columns
// from the row drive, stimulus pushes expected key codes into a scoreboard and
// a monitor pops and compares on every key_valid pulse.
module tb_keypad_row_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;
   localparam int REPEAT_CNT   = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_pressed;

   bit         keys [4][4];
   logic [3:0] code_tab [4][4];
   logic [3:0] sb [$];
   logic [3:0] exp_code;
   logic       prev_valid = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   keypad_row_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .REPEAT_CNT   (REPEAT_CNT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .col         (col),
      .row         (row),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_pressed (key_pressed)
   );

   // Passive keypad: a pressed key shorts its column to its row when that row is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (row[r] == 1'b0 && keys[r][c]) col[c] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every key_valid must match the oldest expected code.
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: got code %0h expected no pulse at %0t", key_code, $time);
         end else begin
            exp_code = sb.pop_front();
            check("key_code", 32'(key_code), 32'(exp_code));
            check("pressed_with_valid", 32'(key_pressed), 32'd1);
         end
         check("valid_one_cycle", 32'(prev_valid), 32'd0);
      end
      prev_valid = key_valid;
   end

   task automatic wait_row(input logic [3:0] want, input string nm);
      int t = 0;
      while (row !== want && t < 200) begin @(negedge clk); t++; end
      check(nm, 32'(row), 32'(want));
   endtask

   task automatic wait_pressed(input logic want, input string nm);
      int t = 0;
      while (key_pressed !== want && t < 400) begin @(negedge clk); t++; end
      check(nm, 32'(key_pressed), 32'(want));
   endtask

   task automatic wait_drain(input string nm);
      int t = 0;
      while (sb.size() != 0 && t < 3000) begin @(negedge clk); t++; end
      check(nm, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_row"},     32'(row),         32'hE);
      check({tag, "_code"},    32'(key_code),    32'h0);
      check({tag, "_valid"},   32'(key_valid),   32'd0);
      check({tag, "_pressed"}, 32'(key_pressed), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] prev_row;
      int         run;
      bit         seen_change;
      int         lat;
      int         r, c;

      code_tab = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                   '{4'h4, 4'h5, 4'h6, 4'hB},
                   '{4'h7, 4'h8, 4'h9, 4'hC},
                   '{4'hE, 4'h0, 4'hF, 4'hD}};
      foreach (keys[i, j]) keys[i][j] = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Idle scan: one-cold rotation, 4-cycle dwell, no key_valid
      prev_row = row; run = 1; seen_change = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (row === prev_row) run++;
         else begin
            if (seen_change) check("idle_dwell", 32'(run), 32'(SCAN_DIV));
            check("idle_rotate", 32'(row), 32'({prev_row[2:0], prev_row[3]}));
            seen_change = 1'b1;
            run = 1;
            prev_row = row;
         end
      end

      // Stable key 5
      wait_row(4'b1110, "k5_wait_row0");
      keys[1][1] = 1'b1;
      sb.push_back(code_tab[1][1]);
      wait_row(4'b1101, "k5_wait_row1");
      lat = 0;
      while (key_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      check("k5_latency_in_range", 32'(lat >= 15 && lat <= 20), 32'd1);
      repeat (10) @(negedge clk);
      check("k5_row_frozen", 32'(row), 32'hD);
      check("k5_held", 32'(key_pressed), 32'd1);
      keys[1][1] = 1'b0;
      repeat (6) @(negedge clk);
      check("k5_pressed_during_release", 32'(key_pressed), 32'd1);
      wait_pressed(1'b0, "k5_released");
      check("k5_row_advanced", 32'(row), 32'hB);
      wait_drain("k5_drain");

      // Key 5 with a bounce on the third debounce sample
      wait_row(4'b1110, "bounce_wait_row0");
      keys[1][1] = 1'b1;
      wait_row(4'b1101, "bounce_wait_row1");
      repeat (12) @(negedge clk);
      keys[1][1] = 1'b0;
      repeat (4) @(negedge clk);
      check("bounce_scan_resumed", 32'(row), 32'hB);
      check("bounce_not_pressed", 32'(key_pressed), 32'd0);
      keys[1][1] = 1'b1;
      sb.push_back(code_tab[1][1]);
      wait_drain("bounce_repress");
      keys[1][1] = 1'b0;
      wait_pressed(1'b0, "bounce_released");

      // * and # together: * wins, # only after * is released
      keys[3][0] = 1'b1;
      keys[3][2] = 1'b1;
      sb.push_back(code_tab[3][0]);
      wait_drain("star_first");
      repeat (10) @(negedge clk);
      keys[3][0] = 1'b0;
      sb.push_back(code_tab[3][2]);
      wait_drain("hash_after_star");
      keys[3][2] = 1'b0;
      wait_pressed(1'b0, "hash_released");

      // Reset during HELD of key A; no report until it is pressed again
      keys[0][3] = 1'b1;
      sb.push_back(code_tab[0][3]);
      wait_drain("a_first");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      keys[0][3] = 1'b0;
      @(negedge clk);
      check_reset_values("midhold_reset");
      rst = 1'b0;
      repeat (200) @(negedge clk);
      keys[0][3] = 1'b1;
      sb.push_back(code_tab[0][3]);
      wait_drain("a_repress");
      keys[0][3] = 1'b0;
      wait_pressed(1'b0, "a_released");

      // Hold key 9 for 20 samples after acceptance
      keys[2][2] = 1'b1;
      sb.push_back(code_tab[2][2]);
      wait_drain("nine_accept");
`ifdef KEYPAD_REPEAT_EN
      for (int k = 0; k < 4; k++) sb.push_back(code_tab[2][2]);
`endif
      repeat (81) @(negedge clk);
      keys[2][2] = 1'b0;
      wait_drain("nine_hold");
      wait_pressed(1'b0, "nine_released");

      // Random single presses
      for (int n = 0; n < 8; n++) begin
         r = $urandom_range(3, 0);
         c = $urandom_range(3, 0);
         repeat ($urandom_range(20, 0)) @(negedge clk);
         keys[r][c] = 1'b1;
         sb.push_back(code_tab[r][c]);
         wait_drain("rand_accept");
         repeat ($urandom_range(8, 0)) @(negedge clk);
         keys[r][c] = 1'b0;
         wait_pressed(1'b0, "rand_released");
      end

      repeat (20) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
